frame_draw_sequencer: RTL and testbench
=======================================

# frame_draw_sequencer

Per-frame draw sequencer placed directly upstream of the layer drawers (background filler, sprite/agent drawers) and directly upstream of the VGA adapter write port. On each frame tick it starts the enabled layers one at a time in fixed priority order, waiting for each layer's `finished` before the next. It forwards the active layer's pixel stream to a single registered `x/y/colour/plot` output. A per-layer watchdog aborts a layer that never finishes.

## Interface
- `NUM_LAYERS`, 4: number of drawer clients; layer 0 is the background and draws first.
- `TIMEOUT_CYCLES`, 65535: maximum cycles a layer may stay active before it is aborted.
- `TIMEOUT_WIDTH`, 20: width of the watchdog counter.
- `clock`  in  1  system clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `frame_tick`  in  1  one-cycle pulse requesting a new frame.
- `enable`  in  1  when low, `frame_tick` is ignored in IDLE.
- `layer_mask`  in  NUM_LAYERS  bit i=1 draws layer i this frame; sampled at frame start.
- `layer_start`  out  NUM_LAYERS  one-cycle start pulse to layer i.
- `layer_finished`  in  NUM_LAYERS  completion pulse from layer i.
- `layer_x`  in  NUM_LAYERS*`X_COORD_WIDTH`  packed; layer i occupies slice i.
- `layer_y`  in  NUM_LAYERS*`Y_COORD_WIDTH`  packed.
- `layer_colour`  in  NUM_LAYERS*`COLOUR_WIDTH`  packed.
- `layer_plot`  in  NUM_LAYERS  write strobes.
- `x`, `y`, `colour`  out  `X_COORD_WIDTH`/`Y_COORD_WIDTH`/`COLOUR_WIDTH`  to VGA adapter.
- `plot`  out  1  VGA write enable.
- `busy`  out  1  high from frame start until DONE exits.
- `frame_done`  out  1  one-cycle pulse at end of frame.
- `overrun`  out  1  one-cycle pulse: `frame_tick` arrived while busy.
- `timeout_err`  out  1  one-cycle pulse: a layer was aborted.

## Operation
- States: IDLE, SEEK, START, WAIT, DONE. `cur` register (layer index) and `mask_q` (latched mask).
- IDLE: on `frame_tick & enable`, latch `mask_q <= layer_mask`, `cur <= 0`, go to SEEK, `busy <= 1`.
- SEEK: if `cur == NUM_LAYERS`, go to DONE. If `mask_q[cur]`, go to START. Otherwise increment `cur` and stay in SEEK. Each skipped layer costs one cycle.
- START: `layer_start[cur]` high for exactly this one cycle; clear watchdog; go to WAIT.
- WAIT: forward layer `cur`'s x/y/colour/plot. When `layer_finished[cur]` is seen, `cur <= cur+1` and go to SEEK. When the watchdog reaches `TIMEOUT_CYCLES-1` without finish, pulse `timeout_err` and advance the same way.
- DONE: pulse `frame_done`, `busy <= 0`, go to IDLE.
- `layer_finished` and `layer_plot` from non-selected layers are ignored.
- `plot` is 0 in every state except WAIT, so no stray writes occur between layers.
- `frame_tick` in any state other than IDLE pulses `overrun` and is dropped, not queued.
- `enable` falling mid-frame does not abort; the current frame completes.
- `cur` width is clog2(NUM_LAYERS+1) so the terminal value is representable.

## Timing
- Reset (async, `resetn` low): state IDLE, `cur` 0, `mask_q` 0, watchdog 0. All outputs 0 (`layer_start`, x, y, colour, plot, busy, frame_done, overrun, timeout_err).
- Pixel path latency: 1 cycle. Output x/y/colour/plot at cycle n+1 equal the selected layer inputs at cycle n, gated by state == WAIT at cycle n.
- Frame with mask 0b0001: tick at cycle 0, SEEK at 1, START at 2 (`layer_start[0]` high), WAIT from 3.
- After `layer_finished` at cycle f, the next enabled layer's start pulse appears at f+2 + (number of skipped layers).
- Mask all zero: `frame_done` at cycle NUM_LAYERS+2 after the tick, with no start pulses.
- Finish and timeout in the same cycle: finish wins and `timeout_err` stays 0.
- Finish in the same cycle as START: ignored, because layer watching begins in WAIT.

## Test plan
- Reset mid-WAIT with `plot` high: all outputs go 0 immediately and asynchronously. After release, state is IDLE and no start pulse occurs until a new tick.
- Mask 0b0101, layers finish 10 cycles after their start: `layer_start[0]` at cycle 2, `layer_start[2]` at cycle 15, `frame_done` 3 cycles after layer 2 finishes; layers 1 and 3 never started.
- Layer 0 drives x=5, y=7, colour=3, plot=1 at cycle 4: outputs equal 5/7/3/1 at cycle 5. Layer 1 plot pulses during the same interval are never forwarded.
- `frame_tick` pulsed while busy: `overrun` pulses 1 cycle later, and exactly one `frame_done` occurs for the frame.
- TIMEOUT_CYCLES=16, layer 1 never finishes: `timeout_err` pulses after 16 WAIT cycles, then layer 2 starts and the frame completes.
- Mask 0 with enable=1: `frame_done` pulses with no `layer_start` and `plot` held 0 throughout. With enable=0, a tick produces no response at all.

Source files
------------

// File: rtl/frame_draw_sequencer_if.sv
// rtl/frame_draw_sequencer_if.sv - layer drawer and VGA write port bundle for the frame draw sequencer
interface frame_draw_sequencer_if #(
    parameter int NUM_LAYERS    = 4,
    parameter int X_COORD_WIDTH = 8,
    parameter int Y_COORD_WIDTH = 7,
    parameter int COLOUR_WIDTH  = 3
) ();
    // Drawer side: one start/finished/plot bit and one packed pixel slice per layer
    logic [NUM_LAYERS-1:0]               layer_start;
    logic [NUM_LAYERS-1:0]               layer_finished;
    logic [NUM_LAYERS*X_COORD_WIDTH-1:0] layer_x;
    logic [NUM_LAYERS*Y_COORD_WIDTH-1:0] layer_y;
    logic [NUM_LAYERS*COLOUR_WIDTH-1:0]  layer_colour;
    logic [NUM_LAYERS-1:0]               layer_plot;

    // VGA adapter write port
    logic [X_COORD_WIDTH-1:0]            x;
    logic [Y_COORD_WIDTH-1:0]            y;
    logic [COLOUR_WIDTH-1:0]             colour;
    logic                                plot;

    modport master (
        output layer_start, x, y, colour, plot,
        input  layer_finished, layer_x, layer_y, layer_colour, layer_plot
    );

    modport slave (
        input  layer_start, x, y, colour, plot,
        output layer_finished, layer_x, layer_y, layer_colour, layer_plot
    );
endinterface

// File: rtl/frame_draw_sequencer.sv
// rtl/frame_draw_sequencer.sv - per-frame layer draw sequencer with watchdog and pixel mux
module frame_draw_sequencer #(
    parameter int NUM_LAYERS     = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TIMEOUT_WIDTH  = 20,
    parameter int X_COORD_WIDTH  = 8,
    parameter int Y_COORD_WIDTH  = 7,
    parameter int COLOUR_WIDTH   = 3
) (
    input  logic                  i_clock,
    input  logic                  i_resetn,
    input  logic                  i_frame_tick,
    input  logic                  i_enable,
    input  logic [NUM_LAYERS-1:0] i_layer_mask,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_overrun,
    output logic                  o_timeout_err,
    frame_draw_sequencer_if.master bus
);

    // cur must reach NUM_LAYERS so SEEK can recognise the end of the frame
    localparam int CUR_W = $clog2(NUM_LAYERS + 1);
    localparam logic [CUR_W-1:0]         CUR_END = CUR_W'(NUM_LAYERS);
    localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEEK,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [CUR_W-1:0]         r_cur;
    logic [CUR_W-1:0]         w_cur_next;
    logic [NUM_LAYERS-1:0]    r_mask_q;
    logic [NUM_LAYERS-1:0]    w_mask_next;
    logic [TIMEOUT_WIDTH-1:0] r_wd;
    logic [TIMEOUT_WIDTH-1:0] w_wd_next;
    logic                     w_timeout;

    logic                     w_sel_mask;
    logic                     w_sel_finished;
    logic                     w_sel_plot;
    logic [X_COORD_WIDTH-1:0] w_sel_x;
    logic [Y_COORD_WIDTH-1:0] w_sel_y;
    logic [COLOUR_WIDTH-1:0]  w_sel_colour;
    logic [NUM_LAYERS-1:0]    w_layer_start;

    logic                     r_overrun;
    logic [X_COORD_WIDTH-1:0] r_x;
    logic [Y_COORD_WIDTH-1:0] r_y;
    logic [COLOUR_WIDTH-1:0]  r_colour;
    logic                     r_plot;

    // Select the mask bit, finish strobe and pixel of the layer indexed by cur; other layers are ignored
    always_comb begin
        w_sel_mask     = 1'b0;
        w_sel_finished = 1'b0;
        w_sel_plot     = 1'b0;
        w_sel_x        = '0;
        w_sel_y        = '0;
        w_sel_colour   = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (r_cur == CUR_W'(i)) begin
                w_sel_mask     = r_mask_q[i];
                w_sel_finished = bus.layer_finished[i];
                w_sel_plot     = bus.layer_plot[i];
                w_sel_x        = bus.layer_x[i*X_COORD_WIDTH +: X_COORD_WIDTH];
                w_sel_y        = bus.layer_y[i*Y_COORD_WIDTH +: Y_COORD_WIDTH];
                w_sel_colour   = bus.layer_colour[i*COLOUR_WIDTH +: COLOUR_WIDTH];
            end
        end
    end

    // Next-state logic: walk the latched mask in priority order, one layer active at a time
    always_comb begin
        w_next_state = r_state;
        w_cur_next   = r_cur;
        w_mask_next  = r_mask_q;
        w_wd_next    = r_wd;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_frame_tick && i_enable) begin
                    w_mask_next  = i_layer_mask;
                    w_cur_next   = '0;
                    w_next_state = S_SEEK;
                end
            end
            S_SEEK: begin
                if (r_cur == CUR_END) begin
                    w_next_state = S_DONE;
                end else if (w_sel_mask) begin
                    w_next_state = S_START;
                end else begin
                    w_cur_next = r_cur + 1'b1;
                end
            end
            S_START: begin
                w_wd_next    = '0;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                // A finish on the last watchdog cycle still counts as a clean finish
                if (w_sel_finished) begin
                    w_cur_next   = r_cur + 1'b1;
                    w_next_state = S_SEEK;
                end else if (r_wd == WD_LAST) begin
                    w_timeout    = 1'b1;
                    w_cur_next   = r_cur + 1'b1;
                    w_next_state = S_SEEK;
                end else begin
                    w_wd_next = r_wd + 1'b1;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Sequencer state, layer index, latched mask and watchdog registers
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state  <= S_IDLE;
            r_cur    <= '0;
            r_mask_q <= '0;
            r_wd     <= '0;
        end else begin
            r_state  <= w_next_state;
            r_cur    <= w_cur_next;
            r_mask_q <= w_mask_next;
            r_wd     <= w_wd_next;
        end
    end

    // One-cycle start pulse to the layer about to be watched
    always_comb begin
        w_layer_start = '0;
        if (r_state == S_START) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                w_layer_start[i] = (r_cur == CUR_W'(i));
            end
        end
    end

    // A tick outside IDLE is dropped and reported one cycle later
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= i_frame_tick && (r_state != S_IDLE);
        end
    end

    // Registered pixel path; forced to zero outside WAIT so nothing is written between layers
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
        end else if (r_state == S_WAIT) begin
            r_x      <= w_sel_x;
            r_y      <= w_sel_y;
            r_colour <= w_sel_colour;
            r_plot   <= w_sel_plot;
        end else begin
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
        end
    end

    assign bus.layer_start = w_layer_start;
    assign bus.x           = r_x;
    assign bus.y           = r_y;
    assign bus.colour      = r_colour;
    assign bus.plot        = r_plot;

    assign o_busy        = (r_state != S_IDLE);
    assign o_frame_done  = (r_state == S_DONE);
    assign o_overrun     = r_overrun;
    assign o_timeout_err = w_timeout;

endmodule

// File: tb/tb_frame_draw_sequencer.sv
// tb/tb_frame_draw_sequencer.sv - scoreboard bench for frame_draw_sequencer
module tb_frame_draw_sequencer;
    localparam int N  = 4;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;

    localparam int K_START = 1 << 24;
    localparam int K_PLOT  = 2 << 24;
    localparam int K_OVR   = 3 << 24;
    localparam int K_TMO   = 4 << 24;
    localparam int K_DONE  = 5 << 24;

    logic         clock = 1'b0;
    logic         resetn = 1'b0;
    logic         frame_tick = 1'b0;
    logic         enable = 1'b0;
    logic [N-1:0] layer_mask = '0;
    logic         busy;
    logic         frame_done;
    logic         overrun;
    logic         timeout_err;

    frame_draw_sequencer_if #(
        .NUM_LAYERS(N), .X_COORD_WIDTH(XW), .Y_COORD_WIDTH(YW), .COLOUR_WIDTH(CW)
    ) bus ();

    frame_draw_sequencer #(
        .NUM_LAYERS(N), .TIMEOUT_CYCLES(16), .TIMEOUT_WIDTH(20),
        .X_COORD_WIDTH(XW), .Y_COORD_WIDTH(YW), .COLOUR_WIDTH(CW)
    ) dut (
        .i_clock       (clock),
        .i_resetn      (resetn),
        .i_frame_tick  (frame_tick),
        .i_enable      (enable),
        .i_layer_mask  (layer_mask),
        .o_busy        (busy),
        .o_frame_done  (frame_done),
        .o_overrun     (overrun),
        .o_timeout_err (timeout_err),
        .bus           (bus)
    );

    typedef struct {
        int code;
        int cyc;
    } ev_t;

    ev_t sb[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  t0 = 0;
    int  dly[N];
    int  due[N];

    initial forever #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pix(input int px, input int py, input int pc);
        return (px << 10) | (py << 3) | pc;
    endfunction

    task automatic expect_ev(input int code, input int rel);
        ev_t e;
        e.code = code;
        e.cyc  = t0 + rel;
        sb.push_back(e);
    endtask

    task automatic observe(input int code);
        ev_t e;
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_event observed=%0h expected=none", code);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("event_code", 32'(code), 32'(e.code));
            check("event_cycle", 32'(cyc), 32'(e.cyc));
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic goto(input int rel);
        while (cyc < t0 + rel) step();
    endtask

    task automatic start_frame();
        t0 = cyc;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    // Monitor: every output event is popped against the scoreboard; starts arm the drawer model
    initial forever begin
        @(negedge clock);
        for (int i = 0; i < N; i++) begin
            if (bus.layer_start[i] === 1'b1) begin
                observe(K_START | i);
                if (dly[i] >= 0) due[i] = cyc + dly[i];
            end
        end
        if (bus.plot === 1'b1) observe(K_PLOT | int'({bus.x, bus.y, bus.colour}));
        if (overrun === 1'b1) observe(K_OVR);
        if (timeout_err === 1'b1) observe(K_TMO);
        if (frame_done === 1'b1) observe(K_DONE);
    end

    // Drawer model: each layer pulses finished a fixed delay after its start
    initial forever begin
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) bus.layer_finished[i] = (cyc == due[i]);
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            dly[i] = -1;
            due[i] = -100;
        end
        bus.layer_finished = '0;
        bus.layer_x        = '0;
        bus.layer_y        = '0;
        bus.layer_colour   = '0;
        bus.layer_plot     = '0;

        #2;
        check("rst_layer_start", 32'(bus.layer_start), 0);
        check("rst_x", 32'(bus.x), 0);
        check("rst_y", 32'(bus.y), 0);
        check("rst_colour", 32'(bus.colour), 0);
        check("rst_plot", 32'(bus.plot), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        step();
        resetn = 1'b1;
        step();
        step();
        enable = 1'b1;

        // Mask 0101, 10-cycle layers, pixel forwarding, layer 1 plot noise, overrun tick
        dly[0] = 10; dly[1] = -1; dly[2] = 10; dly[3] = -1;
        layer_mask = 4'b0101;
        t0 = cyc;
        expect_ev(K_START | 0, 2);
        expect_ev(K_PLOT | pix(5, 7, 3), 5);
        expect_ev(K_OVR, 7);
        expect_ev(K_START | 2, 15);
        expect_ev(K_DONE, 28);
        start_frame();
        check("busy_seek", 32'(busy), 1);
        goto(4);
        bus.layer_x[0 +: XW]      = 8'd5;
        bus.layer_y[0 +: YW]      = 7'd7;
        bus.layer_colour[0 +: CW] = 3'd3;
        bus.layer_x[XW +: XW]     = 8'd1;
        bus.layer_plot            = 4'b0011;
        goto(5);
        bus.layer_plot = 4'b0010;
        goto(6);
        frame_tick = 1'b1;
        goto(7);
        frame_tick = 1'b0;
        bus.layer_plot = 4'b0000;
        goto(32);
        check("busy_after_a", 32'(busy), 0);

        // Empty mask: done after NUM_LAYERS+2 with no starts and no plots
        layer_mask = 4'b0000;
        t0 = cyc;
        expect_ev(K_DONE, N + 2);
        start_frame();
        goto(10);

        // Disabled: tick ignored entirely
        enable = 1'b0;
        start_frame();
        check("disabled_busy", 32'(busy), 0);
        goto(10);
        enable = 1'b1;

        // Layer 1 hangs and is aborted after 16 WAIT cycles; layer 2 then completes
        dly[1] = -1; dly[2] = 5;
        layer_mask = 4'b0110;
        t0 = cyc;
        expect_ev(K_START | 1, 3);
        expect_ev(K_TMO, 19);
        expect_ev(K_START | 2, 21);
        expect_ev(K_DONE, 29);
        start_frame();
        goto(33);

        // Finish on the last watchdog cycle wins over the timeout
        dly[3] = 16;
        layer_mask = 4'b1000;
        t0 = cyc;
        expect_ev(K_START | 3, 5);
        expect_ev(K_DONE, 23);
        start_frame();
        goto(26);

        // Async reset mid-WAIT with plot high, then no activity without a new tick
        for (int i = 0; i < N; i++) dly[i] = -1;
        layer_mask = 4'b0001;
        t0 = cyc;
        expect_ev(K_START | 0, 2);
        expect_ev(K_PLOT | pix(9, 2, 1), 5);
        start_frame();
        goto(4);
        bus.layer_x[0 +: XW]      = 8'd9;
        bus.layer_y[0 +: YW]      = 7'd2;
        bus.layer_colour[0 +: CW] = 3'd1;
        bus.layer_plot            = 4'b0001;
        goto(6);
        check("pre_reset_plot", 32'(bus.plot), 1);
        #1;
        resetn = 1'b0;
        #1;
        check("async_plot", 32'(bus.plot), 0);
        check("async_x", 32'(bus.x), 0);
        check("async_y", 32'(bus.y), 0);
        check("async_colour", 32'(bus.colour), 0);
        check("async_busy", 32'(busy), 0);
        check("async_layer_start", 32'(bus.layer_start), 0);
        step();
        step();
        resetn = 1'b1;
        bus.layer_plot = 4'b0000;
        repeat (8) step();
        check("post_reset_busy", 32'(busy), 0);
        check("sb_empty", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
